// File: rtl/seq_det_pkg.sv
// Shared encodings for the 1011 serial detector: FSM states and default counter width.
package seq_det_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    S0 = 2'b00,  // idle
    S1 = 2'b01,  // seen "1"
    S2 = 2'b10,  // seen "10"
    S3 = 2'b11   // seen "101"
  } state_e;

endpackage

// File: rtl/seq_det_1011_if.sv
// Bundle of the detector's data, control and status signals, with driver/detector views.
interface seq_det_if #(
  parameter int CNT_W = seq_det_pkg::CNT_W_DEFAULT
) (
  input logic clk
);
  logic             d;
  logic             en;
  logic             cnt_clr;
  logic             det;
  logic [CNT_W-1:0] match_cnt;
  logic [1:0]       state_o;

  modport master (
    input  clk,
    output d, en, cnt_clr,
    input  det, match_cnt, state_o
  );

  modport slave (
    input  clk,
    input  d, en, cnt_clr,
    output det, match_cnt, state_o
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses up to all-ones and holds there; clr wins over inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/seq_det_1011.sv
// Serial 1011 detector with registered one-cycle det pulse and saturating match counter.
// SEQ_DET_OVERLAP_EN: when defined, the trailing 1 of a match may start the next one.
module seq_det_1011
  import seq_det_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             en,
  input  logic             cnt_clr,
  output logic             det,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state_o
);
  state_e state_q, state_d;
  logic   det_q, det_d;
  logic   hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
      det_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      det_q   <= det_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    if (en) begin
      unique case (state_q)
        S0: state_d = d ? S1 : S0;
        S1: state_d = d ? S1 : S2;
        S2: state_d = d ? S3 : S0;
        S3: begin
          if (d) begin
            hit = 1'b1;
`ifdef SEQ_DET_OVERLAP_EN
            state_d = S1;
`else
            state_d = S0;
`endif
          end else begin
            state_d = S2;
          end
        end
        default: state_d = S0;
      endcase
    end
  end

  always_comb begin
    det_d   = hit;
    det     = det_q;
    state_o = state_q;
  end

  // Counter clear is independent of the FSM: a detect on a clearing edge still pulses det.
  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .clr (cnt_clr),
    .cnt (match_cnt)
  );
endmodule

// File: tb/tb_seq_det_1011.sv
// Bench for seq_det_1011: default-width and 2-bit-counter instances share stimulus; a history-based scoreboard predicts outputs.
module tb_seq_det_1011;
  import seq_det_pkg::*;

`ifdef SEQ_DET_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  typedef struct packed {
    logic rst;
    logic en;
    logic d;
    logic clr;
  } stim_t;

  typedef struct packed {
    logic       det;
    logic [1:0] st;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  logic clk;
  logic rst;

  seq_det_if #(.CNT_W(8)) bus8 (.clk(clk));
  seq_det_if #(.CNT_W(2)) bus2 (.clk(clk));

  seq_det_1011 #(.CNT_W(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .d         (bus8.d),
    .en        (bus8.en),
    .cnt_clr   (bus8.cnt_clr),
    .det       (bus8.det),
    .match_cnt (bus8.match_cnt),
    .state_o   (bus8.state_o)
  );

  seq_det_1011 #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .d         (bus2.d),
    .en        (bus2.en),
    .cnt_clr   (bus2.cnt_clr),
    .det       (bus2.det),
    .match_cnt (bus2.match_cnt),
    .state_o   (bus2.state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  // Model: history of enabled bits plus how many of them may still take part in a match.
  int       m_n = 0;
  logic [3:0] m_hist = 4'b0;
  int       m_c8 = 0;
  int       m_c2 = 0;

  task automatic drive(input stim_t s);
    exp_t e;
    rst          = s.rst;
    bus8.d       = s.d;
    bus8.en      = s.en;
    bus8.cnt_clr = s.clr;
    bus2.d       = s.d;
    bus2.en      = s.en;
    bus2.cnt_clr = s.clr;
    e.det = 1'b0;
    if (s.rst) begin
      m_n = 0; m_hist = 4'b0; m_c8 = 0; m_c2 = 0;
    end else begin
      if (s.en) begin
        m_hist = {m_hist[2:0], s.d};
        if (m_n < 4) m_n++;
        if (m_n >= 4 && m_hist == 4'b1011) begin
          e.det = 1'b1;
          m_n   = OVL ? 1 : 0;
        end
      end
      if (s.clr) begin
        m_c8 = 0; m_c2 = 0;
      end else if (e.det) begin
        if (m_c8 < 255) m_c8++;
        if (m_c2 < 3) m_c2++;
      end
    end
    if (m_n >= 3 && m_hist[2:0] == 3'b101)     e.st = 2'd3;
    else if (m_n >= 2 && m_hist[1:0] == 2'b10) e.st = 2'd2;
    else if (m_n >= 1 && m_hist[0])            e.st = 2'd1;
    else                                       e.st = 2'd0;
    e.c8 = 8'(m_c8);
    e.c2 = 2'(m_c2);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t bit1(input logic d);
    return '{rst: 1'b0, en: 1'b1, d: d, clr: 1'b0};
  endfunction

  task automatic test_reset();
    stim_t s[$];
    exp_t  e;
    for (int i = 0; i < 2; i++) s.push_back('{rst: 1'b1, en: 1'b1, d: 1'(i), clr: 1'b0});
    foreach (s[i]) begin
      drive(s[i]);
      e = sb_q.pop_front();
      total++;
      if ({bus8.det, bus8.state_o, bus8.match_cnt, bus2.match_cnt, bus2.det, bus2.state_o} !== {e, e.det, e.st}) begin
        bad++;
        $display("FAIL reset[%0d]: got det=%b st=%b c8=%0d c2=%0d det2=%b st2=%b, want det=%b st=%b c8=%0d c2=%0d",
                 i, bus8.det, bus8.state_o, bus8.match_cnt, bus2.match_cnt, bus2.det, bus2.state_o, e.det, e.st, e.c8, e.c2);
      end
    end
  endtask

  task automatic test_stream();
    stim_t s[$];
    exp_t  e;
    logic [6:0] bits = 7'b1011011;
    int pulses = 0;
    for (int i = 6; i >= 0; i--) s.push_back(bit1(bits[i]));
    foreach (s[i]) begin
      drive(s[i]);
      e = sb_q.pop_front();
      total++;
      if (bus8.det === 1'b1) pulses++;
      if ({bus8.det, bus8.state_o, bus8.match_cnt, bus2.match_cnt, bus2.det, bus2.state_o} !== {e, e.det, e.st}) begin
        bad++;
        $display("FAIL stream[%0d]: got det=%b st=%b c8=%0d c2=%0d det2=%b st2=%b, want det=%b st=%b c8=%0d c2=%0d",
                 i, bus8.det, bus8.state_o, bus8.match_cnt, bus2.match_cnt, bus2.det, bus2.state_o, e.det, e.st, e.c8, e.c2);
      end
    end
    total++;
    if (pulses != (OVL ? 2 : 1)) begin
      bad++;
      $display("FAIL stream_pulses: got %0d want %0d", pulses, OVL ? 2 : 1);
    end
  endtask

  task automatic test_enable_hold();
    stim_t s[$];
    exp_t  e;
    s.push_back(bit1(1'b1));
    s.push_back(bit1(1'b0));
    s.push_back(bit1(1'b1));
    for (int i = 0; i < 3; i++) s.push_back('{rst: 1'b0, en: 1'b0, d: 1'b0, clr: 1'b0});
    s.push_back(bit1(1'b1));
    foreach (s[i]) begin
      drive(s[i]);
      e = sb_q.pop_front();
      total++;
      if ({bus8.det, bus8.state_o, bus8.match_cnt, bus2.match_cnt, bus2.det, bus2.state_o} !== {e, e.det, e.st}) begin
        bad++;
        $display("FAIL hold[%0d]: got det=%b st=%b c8=%0d c2=%0d det2=%b st2=%b, want det=%b st=%b c8=%0d c2=%0d",
                 i, bus8.det, bus8.state_o, bus8.match_cnt, bus2.match_cnt, bus2.det, bus2.state_o, e.det, e.st, e.c8, e.c2);
      end
      if (i >= 3 && i <= 5) begin
        total++;
        if (bus8.state_o !== 2'b11) begin
          bad++;
          $display("FAIL hold_state[%0d]: got %b want 11", i, bus8.state_o);
        end
      end
    end
  endtask

  task automatic test_saturate();
    stim_t s[$];
    exp_t  e;
    logic [3:0] pat = 4'b1011;
    s.push_back('{rst: 1'b0, en: 1'b0, d: 1'b0, clr: 1'b1});
    for (int k = 0; k < 5; k++)
      for (int i = 3; i >= 0; i--) s.push_back(bit1(pat[i]));
    for (int i = 3; i >= 1; i--) s.push_back(bit1(pat[i]));
    s.push_back('{rst: 1'b0, en: 1'b1, d: 1'b1, clr: 1'b1});
    foreach (s[i]) begin
      drive(s[i]);
      e = sb_q.pop_front();
      total++;
      if ({bus8.det, bus8.state_o, bus8.match_cnt, bus2.match_cnt, bus2.det, bus2.state_o} !== {e, e.det, e.st}) begin
        bad++;
        $display("FAIL saturate[%0d]: got det=%b st=%b c8=%0d c2=%0d det2=%b st2=%b, want det=%b st=%b c8=%0d c2=%0d",
                 i, bus8.det, bus8.state_o, bus8.match_cnt, bus2.match_cnt, bus2.det, bus2.state_o, e.det, e.st, e.c8, e.c2);
      end
    end
    total++;
    if ({bus2.det, bus2.match_cnt, bus8.match_cnt} !== {1'b1, 2'd0, 8'd0}) begin
      bad++;
      $display("FAIL clr_with_det: got det=%b c2=%0d c8=%0d want det=1 c2=0 c8=0", bus2.det, bus2.match_cnt, bus8.match_cnt);
    end
  endtask

  task automatic test_reset_mid();
    stim_t s[$];
    exp_t  e;
    s.push_back(bit1(1'b1));
    s.push_back(bit1(1'b0));
    s.push_back(bit1(1'b1));
    s.push_back('{rst: 1'b1, en: 1'b1, d: 1'b1, clr: 1'b0});
    s.push_back(bit1(1'b1));
    foreach (s[i]) begin
      drive(s[i]);
      e = sb_q.pop_front();
      total++;
      if ({bus8.det, bus8.state_o, bus8.match_cnt, bus2.match_cnt, bus2.det, bus2.state_o} !== {e, e.det, e.st}) begin
        bad++;
        $display("FAIL reset_mid[%0d]: got det=%b st=%b c8=%0d c2=%0d det2=%b st2=%b, want det=%b st=%b c8=%0d c2=%0d",
                 i, bus8.det, bus8.state_o, bus8.match_cnt, bus2.match_cnt, bus2.det, bus2.state_o, e.det, e.st, e.c8, e.c2);
      end
    end
    total++;
    if ({bus8.det, bus8.state_o} !== {1'b0, 2'b01}) begin
      bad++;
      $display("FAIL reset_mid_final: got det=%b st=%b want det=0 st=01", bus8.det, bus8.state_o);
    end
  endtask

  task automatic test_random();
    stim_t s;
    exp_t  e;
    for (int i = 0; i < 400; i++) begin
      s.rst = ($urandom_range(0, 49) == 0);
      s.en  = ($urandom_range(0, 3) != 0);
      s.d   = ($urandom_range(0, 2) != 0);
      s.clr = ($urandom_range(0, 29) == 0);
      drive(s);
      e = sb_q.pop_front();
      total++;
      if ({bus8.det, bus8.state_o, bus8.match_cnt, bus2.match_cnt, bus2.det, bus2.state_o} !== {e, e.det, e.st}) begin
        bad++;
        $display("FAIL random[%0d]: got det=%b st=%b c8=%0d c2=%0d det2=%b st2=%b, want det=%b st=%b c8=%0d c2=%0d",
                 i, bus8.det, bus8.state_o, bus8.match_cnt, bus2.match_cnt, bus2.det, bus2.state_o, e.det, e.st, e.c8, e.c2);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus8.d       = 1'b0;
    bus8.en      = 1'b0;
    bus8.cnt_clr = 1'b0;
    bus2.d       = 1'b0;
    bus2.en      = 1'b0;
    bus2.cnt_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_enable_hold();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_det_1011.md
SEQ_DET_1011 -- requirements
Module: seq_det_1011

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the match-counter width in bits (legal 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port d, input, 1 bit: serial data bit, the q output of the upstream D flip-flop stage.
REQ-005 The block SHALL have port en, input, 1 bit: d is sampled only on edges where en=1.
REQ-006 The block SHALL have port cnt_clr, input, 1 bit: synchronous clear of the match counter.
REQ-007 The block SHALL have port det, output, 1 bit: registered one-cycle pulse per detected 1011.
REQ-008 The block SHALL have port match_cnt, output, CNT_W bits: saturating count of detections.
REQ-009 The block SHALL have port state_o, output, 2 bits: current FSM state, for debug.

Function
REQ-010 The FSM SHALL have states S0 (idle, encoding 00), S1 ("1", 01), S2 ("10", 10) and S3 ("101", 11).
REQ-011 On an edge with en=1, the FSM SHALL move: S0: d=1->S1, d=0->S0; S1: d=0->S2, d=1->S1; S2: d=1->S3, d=0->S0; S3: d=0->S2, d=1->detect.
REQ-012 A detect (S3 with d=1 and en=1) SHALL set det=1 for exactly the one cycle following that edge.
REQ-013 On a detect, the next state SHALL be set by the configuration in REQ-020/REQ-021.
REQ-014 On an edge with en=0, state SHALL hold and det SHALL be 0 the following cycle.
REQ-015 Latency SHALL be one clock, from the edge sampling the final 1 to det high; there is no combinational path from d to det.
REQ-016 match_cnt SHALL increment by 1 on each detect edge and saturate at 2^CNT_W-1 with no wrap.
REQ-017 When cnt_clr=1 on an edge, match_cnt SHALL become 0 even if a detect occurs on the same edge; the FSM and det are unaffected by cnt_clr.
REQ-018 Back-to-back detects SHALL each produce a pulse, so det may stay high for consecutive cycles only when detects occur on consecutive enabled edges.

Reset
REQ-019 When rst=1 on an edge, the block SHALL set state=S0, det=0 and match_cnt=0, overriding en, d and cnt_clr; reset mid-sequence SHALL discard partial matches.

Configuration
REQ-020 With macro SEQ_DET_OVERLAP_EN defined, a detect SHALL go to S1, so the trailing 1 may start the next match.
REQ-021 Without SEQ_DET_OVERLAP_EN, a detect SHALL go to S0, giving non-overlapping detection; all other transitions are identical.

Structure
REQ-022 State encodings S0..S3 and the default CNT_W SHALL live in a shared package, seq_det_pkg.
REQ-023 The saturating counter SHALL be one sub-module, sat_counter, parameterised by width, with inputs inc and clr and the same clk/rst.
REQ-024 The FSM and det register SHALL be in seq_det_1011; the upstream D flip-flop stage SHALL drive d directly.

Verification
REQ-025 Reset: apply rst=1 for 2 cycles with d toggling -> state_o=00, det=0, match_cnt=0.
REQ-026 With en=1 and stream 1,0,1,1,0,1,1 -> two det pulses (after bits 4 and 7) and match_cnt=2 with SEQ_DET_OVERLAP_EN; one pulse and match_cnt=1 without it.
REQ-027 Stream 1,0,1 then en=0 for 3 cycles with d=0, then en=1 with d=1 -> state held at S3, and a det pulse follows the final bit.
REQ-028 CNT_W=2 and 5 detects -> match_cnt goes 1,2,3,3,3; a cnt_clr asserted on the same edge as a detect -> match_cnt=0 and det=1.
REQ-029 Stream 1,0,1 then rst=1 for one edge, then 1 -> no det pulse and state_o=01.
